// File: rtl/alu_seq_if.sv
// Operand/result bundle for the sequential ALU.
// The master drives the request; the slave returns Q/F with a done pulse.
interface alu_seq_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       S;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Q;
    logic [4:0]       F;

    modport master (
        output start, A, B, S,
        input  busy, done, Q, F
    );

    modport slave (
        input  start, A, B, S,
        output busy, done, Q, F
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle logic/add/sub/shift,
// WIDTH-step shift-add MUL and restoring DIV/MOD.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_NOR = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    typedef enum logic {IDLE, ITER} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [2*WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [4:0]         f_q, f_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    function automatic logic [4:0] flags(
        input logic [WIDTH-1:0] r,
        input logic c,
        input logic v,
        input logic e
    );
        return {r[WIDTH-1], r == '0, c, v, e};
    endfunction

    logic [WIDTH:0]   add_w, sub_w, shl_w;
    logic [WIDTH-1:0] sc_q;
    logic             sc_c, sc_v, sc_e, multi;

    always_comb begin
        add_w = {1'b0, bus.A} + {1'b0, bus.B};
        sub_w = {1'b0, bus.A} - {1'b0, bus.B};
        shl_w = {1'b0, bus.A} << bus.B;
        sc_q  = '0;
        sc_c  = 1'b0;
        sc_v  = 1'b0;
        sc_e  = 1'b0;
        multi = 1'b0;
        unique case (bus.S)
            OP_ADD: begin
                sc_q = add_w[WIDTH-1:0];
                sc_c = add_w[WIDTH];
                sc_v = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                       (add_w[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_q = sub_w[WIDTH-1:0];
                sc_c = sub_w[WIDTH];
                sc_v = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                       (sub_w[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_MUL: multi = 1'b1;
            OP_DIV: begin
                if (bus.B == '0) begin
                    sc_q = '1;
                    sc_e = 1'b1;
                end else begin
                    multi = 1'b1;
                end
            end
            OP_MOD: begin
                if (bus.B == '0) begin
                    sc_q = bus.A;
                    sc_e = 1'b1;
                end else begin
                    multi = 1'b1;
                end
            end
            OP_AND: sc_q = bus.A & bus.B;
            OP_OR:  sc_q = bus.A | bus.B;
            OP_NOR: sc_q = ~(bus.A | bus.B);
            // bit WIDTH of the widened shift is the last bit pushed out
            OP_SHL: begin
                sc_q = shl_w[WIDTH-1:0];
                sc_c = shl_w[WIDTH];
            end
            OP_SHR: sc_q = bus.A >> bus.B;
            default: sc_q = '0;
        endcase
    end

    logic [2*WIDTH-1:0] prod_nx;
    logic [WIDTH:0]     sh_w, dif_w;
    logic               ge;
    logic [WIDTH-1:0]   rem_nx, quo_nx, it_q;
    logic               it_v;

    always_comb begin
        prod_nx = p_q + (x_q[0] ? m_q : '0);
        sh_w    = {p_q[WIDTH-1:0], x_q[WIDTH-1]};
        dif_w   = sh_w - {1'b0, m_q[WIDTH-1:0]};
        ge      = sh_w >= {1'b0, m_q[WIDTH-1:0]};
        rem_nx  = ge ? dif_w[WIDTH-1:0] : sh_w[WIDTH-1:0];
        quo_nx  = {x_q[WIDTH-2:0], ge};
        it_v    = 1'b0;
        unique case (1'b1)
            op_q == OP_MUL: begin
                it_q = prod_nx[WIDTH-1:0];
                it_v = |prod_nx[2*WIDTH-1:WIDTH];
            end
            op_q == OP_DIV: it_q = quo_nx;
            default:        it_q = rem_nx;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        p_d     = p_q;
        m_d     = m_q;
        x_d     = x_q;
        q_d     = q_q;
        f_d     = f_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && multi) begin
                    state_d = ITER;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    op_d    = bus.S;
                    p_d     = '0;
                    // MUL: m=multiplicand, x=multiplier; DIV: m=divisor, x=dividend
                    m_d = {{WIDTH{1'b0}}, (bus.S == OP_MUL) ? bus.A : bus.B};
                    x_d = (bus.S == OP_MUL) ? bus.B : bus.A;
                end else if (bus.start) begin
                    q_d    = sc_q;
                    f_d    = flags(sc_q, sc_c, sc_v, sc_e);
                    done_d = 1'b1;
                end
            end
            ITER: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    p_d = prod_nx;
                    m_d = m_q << 1;
                    x_d = x_q >> 1;
                end else begin
                    p_d = {{WIDTH{1'b0}}, rem_nx};
                    x_d = quo_nx;
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    q_d     = it_q;
                    f_d     = flags(it_q, 1'b0, it_v, 1'b0);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            p_q     <= '0;
            m_q     <= '0;
            x_q     <= '0;
            q_q     <= '0;
            f_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            p_q     <= p_d;
            m_q     <= m_d;
            x_q     <= x_d;
            q_q     <= q_d;
            f_q     <= f_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Q    = q_q;
    assign bus.F    = f_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=4 and WIDTH=8.
// Expected results are queued at issue and popped on each done pulse.
module tb_alu_seq;
    logic clk;
    logic rst;

    alu_seq_if #(.WIDTH(4)) if4();
    alu_seq_if #(.WIDTH(8)) if8();

    alu_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] v;
        string      tag;
    } exp_t;

    exp_t exp4[$];
    exp_t exp8[$];
    int   ntests = 0;
    int   nfail  = 0;
    int   ndone4 = 0;
    int   ndone8 = 0;
    int   npush4 = 0;
    int   npush8 = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent integer model, returns {Q[3:0], N, Z, C, V, E}
    function automatic logic [8:0] model4(input int s, input int a,
                                          input int b);
        int q, c, v, e, sa, sb, r;
        q = 0; c = 0; v = 0; e = 0;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        case (s)
            0: begin
                r = a + b; q = r % 16; c = (r > 15) ? 1 : 0;
                v = ((sa + sb) > 7 || (sa + sb) < -8) ? 1 : 0;
            end
            1: begin
                r = a - b; q = (r + 16) % 16; c = (a < b) ? 1 : 0;
                v = ((sa - sb) > 7 || (sa - sb) < -8) ? 1 : 0;
            end
            2: begin
                r = a * b; q = r % 16; v = (r > 15) ? 1 : 0;
            end
            3: if (b == 0) begin q = 15; e = 1; end else q = a / b;
            4: if (b == 0) begin q = a; e = 1; end else q = a % b;
            5: q = a & b;
            6: q = a | b;
            7: q = 15 - (a | b);
            8: begin
                q = (b < 4) ? (a << b) % 16 : 0;
                c = (b >= 1 && b <= 4) ? (a >> (4 - b)) & 1 : 0;
            end
            9: q = (b < 4) ? (a >> b) : 0;
            default: q = 0;
        endcase
        return {4'(q), q > 7, q == 0, c != 0, v != 0, e != 0};
    endfunction

    // WIDTH=8 reference: {Q[7:0], C}
    function automatic logic [8:0] model8(input int s, input int a,
                                          input int b);
        int r;
        case (s)
            0: begin r = a + b; return {8'(r % 256), r > 255}; end
            2: return {8'((a * b) % 256), 1'b0};
            3: return {8'(a / b), 1'b0};
            default: return 9'd0;
        endcase
    endfunction

    task automatic push4(input int s, input int a, input int b,
                         input string tag);
        exp_t x;
        x.v = model4(s, a, b);
        x.tag = tag;
        exp4.push_back(x);
        npush4++;
    endtask

    always @(negedge clk) begin
        if (if4.done) begin
            ndone4++;
            if (exp4.size() == 0) begin
                check("spurious_done4", {31'b0, if4.done}, 0);
            end else begin
                exp_t x;
                x = exp4.pop_front();
                check({x.tag, "_Q"}, {28'b0, if4.Q}, {28'b0, x.v[8:5]});
                check({x.tag, "_F"}, {27'b0, if4.F}, {27'b0, x.v[4:0]});
            end
        end
        if (if8.done) begin
            ndone8++;
            if (exp8.size() == 0) begin
                check("spurious_done8", {31'b0, if8.done}, 0);
            end else begin
                exp_t x;
                x = exp8.pop_front();
                check({x.tag, "_Q"}, {24'b0, if8.Q}, {24'b0, x.v[8:1]});
                check({x.tag, "_C"}, {31'b0, if8.F[2]}, {31'b0, x.v[0]});
            end
        end
    end

    // Called at a negedge; returns at the negedge after the done pulse.
    task automatic run4(input int s, input int a, input int b,
                        input string tag);
        int  k;
        bit  it;
        it = (s == 2) || ((s == 3 || s == 4) && b != 0);
        push4(s, a, b, tag);
        if4.S = 4'(s); if4.A = 4'(a); if4.B = 4'(b); if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        k = 1;
        while (!if4.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, k, it ? 5 : 1);
        check({tag, "_busy"}, {31'b0, if4.busy}, 0);
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, if4.done}, 0);
    endtask

    task automatic run8(input int s, input int a, input int b,
                        input string tag);
        int   k;
        exp_t x;
        x.v = model8(s, a, b);
        x.tag = tag;
        exp8.push_back(x);
        npush8++;
        if8.S = 4'(s); if8.A = 8'(a); if8.B = 8'(b); if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        k = 1;
        while (!if8.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, k, (s == 0) ? 1 : 9);
        @(negedge clk);
    endtask

    initial begin
        int k;
        int snap;
        rst = 1'b1;
        if4.start = 1'b0; if4.A = '0; if4.B = '0; if4.S = '0;
        if8.start = 1'b0; if8.A = '0; if8.B = '0; if8.S = '0;
        #2;
        check("rst_Q", {28'b0, if4.Q}, 0);
        check("rst_F", {27'b0, if4.F}, 0);
        check("rst_busy", {31'b0, if4.busy}, 0);
        check("rst_done", {31'b0, if4.done}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run4(0, 15, 3, "add_carry");
        run4(1, 3, 15, "sub_borrow");
        run4(1, 8, 1, "sub_ovf");
        run4(2, 3, 5, "mul_3x5");
        check("mul_3x5_spec", {28'b0, if4.Q}, 32'hF);
        run4(2, 4, 4, "mul_ovf");
        run4(2, 15, 15, "mul_15x15");
        run4(3, 9, 3, "div_9_3");
        run4(4, 9, 3, "mod_9_3");
        run4(3, 9, 0, "div_zero");
        run4(4, 9, 0, "mod_zero");
        run4(5, 12, 10, "and");
        run4(7, 5, 2, "nor");
        run4(9, 12, 2, "shr_2");
        run4(9, 12, 5, "shr_big");
        run4(8, 3, 1, "shl_1");
        run4(8, 9, 3, "shl_3");
        run4(10, 7, 7, "op_unused");

        // start while busy must be ignored and operand changes harmless
        push4(2, 3, 5, "mul_ignore");
        if4.S = 4'd2; if4.A = 4'd3; if4.B = 4'd5; if4.start = 1'b1;
        @(negedge clk);
        check("ign_busy", {31'b0, if4.busy}, 1);
        if4.S = 4'd0; if4.A = 4'd15; if4.B = 4'd15;
        @(negedge clk);
        if4.start = 1'b0; if4.A = 4'd7; if4.B = 4'd1;
        k = 2;
        while (!if4.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("ign_lat", k, 5);
        repeat (3) @(negedge clk);
        check("ign_ndone", ndone4, npush4);

        // start held high: back-to-back single-cycle ops
        push4(0, 1, 2, "b2b_add");
        if4.S = 4'd0; if4.A = 4'd1; if4.B = 4'd2; if4.start = 1'b1;
        @(negedge clk);
        check("b2b_done1", {31'b0, if4.done}, 1);
        push4(5, 6, 3, "b2b_and");
        if4.S = 4'd5; if4.A = 4'd6; if4.B = 4'd3;
        @(negedge clk);
        check("b2b_done2", {31'b0, if4.done}, 1);
        if4.start = 1'b0;
        @(negedge clk);
        check("b2b_end", {31'b0, if4.done}, 0);

        // reset in the middle of a DIV aborts it silently
        snap = ndone4;
        if4.S = 4'd3; if4.A = 4'd9; if4.B = 4'd3; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        check("mid_busy", {31'b0, if4.busy}, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_Q", {28'b0, if4.Q}, 0);
        check("mid_rst_F", {27'b0, if4.F}, 0);
        check("mid_rst_busy", {31'b0, if4.busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_rst_nodone", ndone4, snap);

        run4(6, 13, 10, "or");
        run4(8, 3, 4, "shl_4");

        for (int i = 0; i < 24; i++) begin
            int s, a, b;
            s = $urandom_range(0, 11);
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            run4(s, a, b, $sformatf("rnd%0d_op%0d", i, s));
        end

        run8(0, 200, 100, "w8_add");
        run8(2, 15, 17, "w8_mul");
        run8(2, 16, 16, "w8_mul_wrap");
        run8(3, 200, 7, "w8_div");

        repeat (3) @(negedge clk);
        check("n_done4", ndone4, npush4);
        check("n_done8", ndone8, npush8);
        check("sb_left4", exp4.size(), 0);
        check("sb_left8", exp8.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
